// File: rtl/disp_dec_pkg.sv
// disp_dec_pkg: segment type and active-low seven-segment patterns, order {g,f,e,d,c,b,a}.
package disp_dec_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_MINUS = 7'h3F;
    localparam seg_t SEG_BLANK = 7'h7F;

    function automatic seg_t seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = SEG_0;
            4'd1:    seg_of = SEG_1;
            4'd2:    seg_of = SEG_2;
            4'd3:    seg_of = SEG_3;
            4'd4:    seg_of = SEG_4;
            4'd5:    seg_of = SEG_5;
            4'd6:    seg_of = SEG_6;
            4'd7:    seg_of = SEG_7;
            4'd8:    seg_of = SEG_8;
            4'd9:    seg_of = SEG_9;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/disp_dec_digit.sv
// disp_dec_digit: one decimal stage; shows v mod 10 and forwards v/10 plus a still-pending sign.
// With DISP_DEC_LZB_EN, a zero non-first stage becomes the minus (or blank) and consumes the sign.
module disp_dec_digit
    import disp_dec_pkg::*;
(
    input  logic [7:0] val_i,
    input  logic       sign_i,
    input  logic       first_i,
    output seg_t       seg_o,
    output logic [7:0] quo_o,
    output logic       pend_o
);
    logic [3:0] dig;
    assign dig   = 4'(val_i % 8'd10);
    assign quo_o = val_i / 8'd10;
`ifdef DISP_DEC_LZB_EN
    logic show;
    assign show   = first_i || (val_i != 8'd0);
    assign seg_o  = show ? seg_of(dig) : (sign_i ? SEG_MINUS : SEG_BLANK);
    assign pend_o = show && sign_i;
`else
    logic unused_first;
    assign unused_first = first_i;
    assign seg_o        = seg_of(dig);
    assign pend_o       = sign_i;
`endif
endmodule

// File: rtl/disp_dec.sv
// disp_dec: registered signed 8-bit to 4-position seven-segment decoder, latency 1.
// Optional leading-zero blanking with DISP_DEC_LZB_EN; ACTIVE_LOW=0 inverts all segments.
module disp_dec
    import disp_dec_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] num,
    output logic       sign,
    output logic [7:0] mag,
    output seg_t       hex0,
    output seg_t       hex1,
    output seg_t       hex2,
    output seg_t       hex3
);
    localparam seg_t BLANK = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    logic            sign_d, sign_q;
    logic [7:0]      mag_d, mag_q;
    logic [3:0][6:0] hex_d, hex_q;
    logic [3:0][7:0] val;
    logic [3:0]      pend;
    logic [2:0][6:0] seg;
    logic [7:0]      unused_val;

    // 8-bit negate wraps -128 to 8'h80, which reads as 128 unsigned.
    assign sign_d     = num[7];
    assign mag_d      = num[7] ? -num : num;
    assign val[0]     = mag_d;
    assign pend[0]    = sign_d;
    assign unused_val = val[3];

    for (genvar i = 0; i < 3; i++) begin : g_dig
        disp_dec_digit u_dig (
            .val_i  (val[i]),
            .sign_i (pend[i]),
            .first_i(1'(i == 0)),
            .seg_o  (seg[i]),
            .quo_o  (val[i+1]),
            .pend_o (pend[i+1])
        );
        assign hex_d[i] = ACTIVE_LOW ? seg[i] : ~seg[i];
    end

    assign hex_d[3] = ACTIVE_LOW ? (pend[3] ? SEG_MINUS : SEG_BLANK)
                                 : ~(pend[3] ? SEG_MINUS : SEG_BLANK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q <= 1'b0;
            mag_q  <= 8'd0;
            hex_q  <= {4{BLANK}};
        end else begin
            sign_q <= sign_d;
            mag_q  <= mag_d;
            hex_q  <= hex_d;
        end
    end

    assign sign = sign_q;
    assign mag  = mag_q;
    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
endmodule

// File: tb/tb_disp_dec.sv
// tb_disp_dec: directed vector table plus reset/latency sequences for disp_dec (either DISP_DEC_LZB_EN build).
module tb_disp_dec;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] num = 8'h00;
    logic       sign;
    logic [7:0] mag;
    logic [6:0] hex0, hex1, hex2, hex3;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] num;
        logic       sign;
        logic [7:0] mag;
        logic [6:0] h0, h1, h2, h3;
    } vec_t;

    vec_t vt[11];

    disp_dec dut (
        .clk (clk),
        .rst (rst),
        .num (num),
        .sign(sign),
        .mag (mag),
        .hex0(hex0),
        .hex1(hex1),
        .hex2(hex2),
        .hex3(hex3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".sign"}, int'(sign), int'(v.sign));
        chk({tag, ".mag"},  int'(mag),  int'(v.mag));
        chk({tag, ".hex0"}, int'(hex0), int'(v.h0));
        chk({tag, ".hex1"}, int'(hex1), int'(v.h1));
        chk({tag, ".hex2"}, int'(hex2), int'(v.h2));
        chk({tag, ".hex3"}, int'(hex3), int'(v.h3));
    endtask

    task automatic chk_blank(input string tag);
        vec_t b;
        b = '{8'h00, 1'b0, 8'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        chk_all(tag, b);
    endtask

    initial begin
`ifdef DISP_DEC_LZB_EN
        vt[0]  = '{8'hF5, 1'b1, 8'd11,  7'h79, 7'h79, 7'h3F, 7'h7F};
        vt[1]  = '{8'h00, 1'b0, 8'd0,   7'h40, 7'h7F, 7'h7F, 7'h7F};
        vt[2]  = '{8'h7F, 1'b0, 8'd127, 7'h78, 7'h24, 7'h79, 7'h7F};
        vt[3]  = '{8'h80, 1'b1, 8'd128, 7'h00, 7'h24, 7'h79, 7'h3F};
        vt[4]  = '{8'hFF, 1'b1, 8'd1,   7'h79, 7'h3F, 7'h7F, 7'h7F};
        vt[5]  = '{8'h09, 1'b0, 8'd9,   7'h10, 7'h7F, 7'h7F, 7'h7F};
        vt[6]  = '{8'h0A, 1'b0, 8'd10,  7'h40, 7'h79, 7'h7F, 7'h7F};
        vt[7]  = '{8'h64, 1'b0, 8'd100, 7'h40, 7'h40, 7'h79, 7'h7F};
        vt[8]  = '{8'h9C, 1'b1, 8'd100, 7'h40, 7'h40, 7'h79, 7'h3F};
        vt[9]  = '{8'hA1, 1'b1, 8'd95,  7'h12, 7'h10, 7'h3F, 7'h7F};
        vt[10] = '{8'h2D, 1'b0, 8'd45,  7'h12, 7'h19, 7'h7F, 7'h7F};
`else
        vt[0]  = '{8'hF5, 1'b1, 8'd11,  7'h79, 7'h79, 7'h40, 7'h3F};
        vt[1]  = '{8'h00, 1'b0, 8'd0,   7'h40, 7'h40, 7'h40, 7'h7F};
        vt[2]  = '{8'h7F, 1'b0, 8'd127, 7'h78, 7'h24, 7'h79, 7'h7F};
        vt[3]  = '{8'h80, 1'b1, 8'd128, 7'h00, 7'h24, 7'h79, 7'h3F};
        vt[4]  = '{8'hFF, 1'b1, 8'd1,   7'h79, 7'h40, 7'h40, 7'h3F};
        vt[5]  = '{8'h09, 1'b0, 8'd9,   7'h10, 7'h40, 7'h40, 7'h7F};
        vt[6]  = '{8'h0A, 1'b0, 8'd10,  7'h40, 7'h79, 7'h40, 7'h7F};
        vt[7]  = '{8'h64, 1'b0, 8'd100, 7'h40, 7'h40, 7'h79, 7'h7F};
        vt[8]  = '{8'h9C, 1'b1, 8'd100, 7'h40, 7'h40, 7'h79, 7'h3F};
        vt[9]  = '{8'hA1, 1'b1, 8'd95,  7'h12, 7'h10, 7'h40, 7'h3F};
        vt[10] = '{8'h2D, 1'b0, 8'd45,  7'h12, 7'h19, 7'h40, 7'h7F};
`endif
        num = 8'hF5;
        repeat (2) @(posedge clk);
        #1 chk_blank("reset_hold");

        @(negedge clk) rst = 1'b0;
        // Back-to-back: a new value every cycle, checked 1 ns after each edge.
        for (int k = 0; k < 11; k++) begin
            @(negedge clk) num = vt[k].num;
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", k), vt[k]);
        end

        // Latency: a new num must not appear before the next edge.
        @(negedge clk) num = vt[0].num;
        #1 chk("latency.mag_hold", int'(mag), int'(vt[10].mag));
        @(posedge clk);
        #1 chk_all("latency", vt[0]);

        // Asynchronous reset mid-cycle after a -1 display.
        @(negedge clk) num = vt[4].num;
        @(posedge clk);
        #1 chk_all("pre_rst", vt[4]);
        #2 rst = 1'b1;
        #1 chk_blank("async_rst");
        @(posedge clk);
        #1 chk_blank("rst_clocked");

        // Release reset: first edge loads the current num; in-flight -1 discarded.
        @(negedge clk) begin
            rst = 1'b0;
            num = vt[2].num;
        end
        @(posedge clk);
        #1 chk_all("post_rst", vt[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/disp_dec.md
DISP_DEC -- requirements
Module: disp_dec

Interface
REQ-001 SHALL have parameter ACTIVE_LOW, default 1: 1 = segment lit by driving 0; 0 = all segment outputs inverted.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port list SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- num  in  8  two's-complement value to display
- sign  out  1  registered 1 when num < 0
- mag  out  8  registered |num|, range 0..128
- hex0  out  7  units digit
- hex1  out  7  tens digit
- hex2  out  7  hundreds digit
- hex3  out  7  sign-only position
REQ-004 Segment order SHALL be {g,f,e,d,c,b,a}.

Function
REQ-005 Signed conversion SHALL set sign = num[7] and mag = num[7] ? -num : num, computed at 8 bits so -128 yields 128.
REQ-006 Digit stages SHALL chain: stage k outputs the digit (v mod 10) and passes (v / 10) plus the sign flag to stage k+1; stage 0 input is mag.
REQ-007 Active-low patterns SHALL be: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, minus=0x3F, blank=0x7F.
REQ-008 hex0 SHALL always show a digit, including 0.
REQ-009 hex1 and hex2: stage input nonzero -> digit; zero and not yet signed -> minus if sign, else blank; further left -> blank.
REQ-010 Exactly one minus SHALL appear for negative inputs, in the position immediately left of the most significant digit; hex3 shows minus only when mag >= 100, else blank.
REQ-011 Conversion and decode SHALL be combinational from num; all outputs SHALL be registered, latency 1 clock; a new num is accepted every cycle.
REQ-012 No division operator SHALL be used on the 8-bit path other than constant /10 and %10; results SHALL be exact for 0..128.

Reset
REQ-013 While rst = 1, and asynchronously on its assertion, sign = 0, mag = 0 and hex0..hex3 = blank.
REQ-014 After rst deasserts, the first rising edge SHALL load the outputs from the current num; reset mid-stream SHALL discard the in-flight value.

Configuration
REQ-015 With macro DISP_DEC_LZB_EN defined, leading-zero blanking SHALL follow REQ-009/REQ-010.
REQ-016 Without DISP_DEC_LZB_EN, hex0..hex2 SHALL always show digits, including leading zeros, and hex3 SHALL show minus when sign = 1, else blank.

Structure
REQ-017 Package disp_dec_pkg SHALL hold the segment pattern constants (SEG_0..SEG_9, SEG_MINUS, SEG_BLANK) and the segment-vector typedef.
REQ-018 One sub-module, disp_dec_digit, SHALL be instantiated three times. Inputs: value 8 bits, sign flag, first-digit flag. Outputs: segments, value/10, pending-sign flag.
REQ-019 The sign/magnitude conversion SHALL be inline logic in disp_dec.

Verification (DISP_DEC_LZB_EN defined, ACTIVE_LOW = 1)
REQ-020 num = 0xF5 (-11) -> after 1 clock: sign = 1, mag = 11, hex0 = 0x79, hex1 = 0x79, hex2 = 0x3F, hex3 = 0x7F.
REQ-021 num = 0x00 -> hex0 = 0x40, hex1..hex3 = 0x7F, sign = 0.
REQ-022 num = 0x7F -> hex0 = 0x78, hex1 = 0x24, hex2 = 0x79, hex3 = 0x7F.
REQ-023 num = 0x80 -> mag = 128, hex0 = 0x00, hex1 = 0x24, hex2 = 0x79, hex3 = 0x3F.
REQ-024 num = 0xFF -> hex0 = 0x79, hex1 = 0x3F, hex2 = hex3 = 0x7F; then assert rst mid-cycle -> all hex = 0x7F immediately, mag = 0.
REQ-025 Without DISP_DEC_LZB_EN, num = 0xF5 -> hex0 = 0x79, hex1 = 0x79, hex2 = 0x40, hex3 = 0x3F.
